ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the multi-digit seven-segment display.
//  Holds a tear-free shadow copy of a NUM_DIGITS-nibble value (PC / ALU result).
//  Selects one digit at a time, presents its 4-bit nibble to the downstream
//  ssd_driver decoder and drives the active-low common anodes.
//  Optional leading-zero blanking; dead-time between digits prevents ghosting.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned, legal 1..8
//  REFRESH_DIV  100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit), >= DEAD_CYC+2
//  DEAD_CYC     64      cycles at start of each slot with all anodes off, >= 0
// PORTS
//  clk        in   1              system clock, all state on rising edge
//  rst_n      in   1              asynchronous active-low reset
//  data_in    in   4*NUM_DIGITS   value to display, nibble i -> digit i (digit 0 = rightmost)
//  load       in   1              1-cycle strobe: capture data_in
//  lz_blank   in   1              1 = blank leading zero digits
//  digit_bcd  out  4              nibble of the active digit, feeds ssd_driver in_BCD
//  anode_n    out  NUM_DIGITS     one-cold digit enable, all 1 = display dark
//  frame_tick out  1              1-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset (async assert, sync release): div_cnt=0, digit_sel=0, shadow=0, pending=0,
//   pend_flag=0, digit_bcd=4'h0, anode_n=all 1, frame_tick=0.
//  Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. slot_end = (div_cnt==REFRESH_DIV-1).
//  On slot_end: digit_sel increments and wraps NUM_DIGITS-1 -> 0.
//  frame_end = slot_end && digit_sel==NUM_DIGITS-1. frame_tick is registered: high the
//   cycle after frame_end.
//  Load: load=1 captures data_in into pending and sets pend_flag (last load wins).
//  Shadow update happens only on frame_end, so a frame never mixes old and new digits:
//   - pend_flag=1: shadow<=pending, pend_flag<=0.
//   - load=1 in the frame_end cycle: shadow<=data_in directly, pend_flag<=0 (bypass wins).
//   - otherwise shadow holds.
//  Blanking: digit i (i>0) is blanked when lz_blank=1 and shadow nibbles i..NUM_DIGITS-1
//   are all zero. Digit 0 is never blanked, so a value of 0 shows "0".
//  Outputs are registered, 1-cycle latency from (div_cnt, digit_sel):
//   - digit_bcd <= shadow[4*digit_sel +: 4].
//   - anode_n <= all 1 if div_cnt < DEAD_CYC or the digit is blanked, else ~(1<<digit_sel).
//  At most one anode_n bit is low at any time. digit_bcd already holds the new nibble
//   when the anode turns on.
//  lz_blank is sampled every cycle and may change mid-frame.
//  Reset mid-frame: display goes dark immediately (async). Pending data is lost.
//  Scan restarts at digit 0, div_cnt 0.
//  NUM_DIGITS=1: digit_sel stays 0 and every slot_end is a frame_end.
// STRUCTURE
//  ssd_pkg: SSD_REFRESH_DIV_DEF, SSD_DEAD_CYC_DEF, function clog2 (sizes div_cnt and
//   digit_sel), localparam helpers for anode patterns.
//  One sub-module: ssd_refresh_div (div_cnt, slot_end). Digit select, shadow/pending
//   registers, blanking and output registers live in ssd_scan_ctrl.
//  digit_bcd connects straight to ssd_driver.in_BCD. Top level maps out_SSD/anode_n to pins.
// TESTING (bench uses REFRESH_DIV=8, DEAD_CYC=2, NUM_DIGITS=4)
//  Reset, then idle 40 cycles -> anode_n pattern E,D,B,7 in order, each low for 6 of 8 cycles;
//   digit_bcd=0; frame_tick every 32 cycles.
//  load 16'h12A4 mid-frame -> the current frame still shows 0000; from the next frame
//   digits read 4,A,2,1; frame_tick is aligned to the swap.
//  load 16'h0007 then 16'h0050 in the same frame -> only 0050 is displayed (last wins).
//   With lz_blank=1, digits 3 and 2 stay dark (anode_n=F in their slots).
//  load 16'hBEEF exactly in the frame_end cycle -> BEEF is shown from the next frame;
//   an earlier pending value is discarded.
//  lz_blank=1 with value 0000 -> only digit 0 lights, showing 0.
//  Assert rst_n low mid-slot -> anode_n=F in the same cycle. After release, the scan
//   restarts at digit 0 with value 0000.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared defaults and helpers for the seven-segment scan controller
package ssd_pkg;

    localparam int SSD_REFRESH_DIV_DEF = 100000;
    localparam int SSD_DEAD_CYC_DEF    = 64;
    localparam int SSD_MAX_DIGITS      = 8;

    localparam logic [SSD_MAX_DIGITS-1:0] SSD_ANODE_ALL_OFF = '1;

    // Width needed to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // One-cold anode pattern for the selected digit, widest display size.
    function automatic logic [SSD_MAX_DIGITS-1:0] ssd_anode_sel(input int sel);
        return ~(SSD_MAX_DIGITS'(1) << sel);
    endfunction

endpackage

// File: rtl/ssd_refresh_div.sv
// rtl/ssd_refresh_div.sv - digit-slot prescaler, flags the last cycle of each slot
module ssd_refresh_div
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = SSD_REFRESH_DIV_DEF,
    parameter int DIV_W       = clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [DIV_W-1:0] div_cnt,
    output logic             slot_end
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    assign slot_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multiplexed seven-segment scan with tear-free shadow and blanking
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = SSD_REFRESH_DIV_DEF,
    parameter int DEAD_CYC    = SSD_DEAD_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_tick
);

    localparam int DIV_W = clog2(REFRESH_DIV);
    localparam int SEL_W = clog2(NUM_DIGITS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic                    slot_end;
    logic                    frame_end;
    logic [SEL_W-1:0]        digit_sel;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_flag;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [3:0]              sel_nib;
    logic                    sel_blank;
    logic                    dead;
    logic [SSD_MAX_DIGITS-1:0] anode_sel_w;

    ssd_refresh_div #(
        .REFRESH_DIV (REFRESH_DIV),
        .DIV_W       (DIV_W)
    ) u_refresh_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_cnt  (div_cnt),
        .slot_end (slot_end)
    );

    assign frame_end   = slot_end && (digit_sel == LAST_SEL);
    assign dead        = (int'(div_cnt) < DEAD_CYC);
    assign anode_sel_w = ssd_anode_sel(int'(digit_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel <= '0;
        end else if (slot_end) begin
            digit_sel <= (digit_sel == LAST_SEL) ? '0 : digit_sel + SEL_W'(1);
        end
    end

    // Shadow only changes at the frame boundary; a load landing on it bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (load) begin
                pending <= data_in;
            end
            if (frame_end) begin
                pend_flag <= 1'b0;
                if (load) begin
                    shadow <= data_in;
                end else if (pend_flag) begin
                    shadow <= pending;
                end
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (shadow[4*i +: 4] == 4'h0);
            blank[i]   = lz_blank && zero_above;
        end
    end

    always_comb begin
        sel_nib   = 4'h0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel == SEL_W'(i)) begin
                sel_nib   = shadow[4*i +: 4];
                sel_blank = blank[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_bcd  <= 4'h0;
            anode_n    <= SSD_ANODE_ALL_OFF[NUM_DIGITS-1:0];
            frame_tick <= 1'b0;
        end else begin
            digit_bcd  <= sel_nib;
            frame_tick <= frame_end;
            if (dead || sel_blank) begin
                anode_n <= SSD_ANODE_ALL_OFF[NUM_DIGITS-1:0];
            end else begin
                anode_n <= anode_sel_w[NUM_DIGITS-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - scoreboard bench for the seven-segment scan controller
module tb_ssd_scan_ctrl;

    localparam int ND   = 4;
    localparam int DIV  = 8;
    localparam int DEAD = 2;
    localparam int FRM  = ND * DIV;

    logic          clk;
    logic          rst_n;
    logic [15:0]   data_in;
    logic          load;
    logic          lz_blank;
    logic [3:0]    digit_bcd;
    logic [ND-1:0] anode_n;
    logic          frame_tick;

    typedef struct packed {
        logic [3:0]    bcd;
        logic [ND-1:0] anode;
        logic          ft;
    } exp_t;

    exp_t sb[$];

    int n_total;
    int n_pass;
    int t;
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    logic        m_pflag;

    ssd_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .DEAD_CYC    (DEAD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .digit_bcd  (digit_bcd),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model: slot timing derived from cycles since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t         = 0;
            m_shadow  = '0;
            m_pending = '0;
            m_pflag   = 1'b0;
            sb.delete();
        end else begin
            int   k;
            int   d;
            logic blk;
            logic [3:0] nib;
            exp_t e;
            k   = t % DIV;
            d   = (t / DIV) % ND;
            nib = m_shadow[4*d +: 4];
            blk = 1'b0;
            if (lz_blank && d > 0 && (m_shadow >> (4*d)) == 16'h0) blk = 1'b1;
            e.bcd   = nib;
            e.anode = (k < DEAD || blk) ? 4'hF : ~(4'h1 << d);
            e.ft    = (k == DIV - 1) && (d == ND - 1);
            sb.push_back(e);
            if (e.ft) begin
                if (load) m_shadow = data_in;
                else if (m_pflag) m_shadow = m_pending;
                m_pflag = 1'b0;
            end else if (load) begin
                m_pending = data_in;
                m_pflag   = 1'b1;
            end
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("digit_bcd", 32'(digit_bcd), 32'(e.bcd));
            check("anode_n", 32'(anode_n), 32'(e.anode));
            check("frame_tick", 32'(frame_tick), 32'(e.ft));
            check("one_cold", 32'($countones(~anode_n) <= 1), 32'd1);
        end
    end

    task automatic wait_phase(input int ph);
        int i;
        i = 0;
        while ((t % FRM) != ph && i < 2 * FRM) begin
            @(negedge clk);
            i++;
        end
        check("phase_reached", 32'((t % FRM) == ph), 32'd1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        data_in = v;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        data_in  = '0;
        load     = 1'b0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(digit_bcd), 32'h0);
        check("rst_anode", 32'(anode_n), 32'hF);
        check("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        repeat (64) @(negedge clk);

        wait_phase(12);
        pulse_load(16'h12A4);
        repeat (80) @(negedge clk);

        lz_blank = 1'b1;
        wait_phase(5);
        pulse_load(16'h0007);
        wait_phase(20);
        pulse_load(16'h0050);
        repeat (80) @(negedge clk);

        lz_blank = 1'b0;
        wait_phase(10);
        pulse_load(16'h3333);
        wait_phase(31);
        pulse_load(16'hBEEF);
        repeat (70) @(negedge clk);

        lz_blank = 1'b1;
        pulse_load(16'h0000);
        repeat (70) @(negedge clk);

        wait_phase(5);
        check("pre_rst_anode", 32'(anode_n), 32'hE);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_anode", 32'(anode_n), 32'hF);
        check("async_rst_bcd", 32'(digit_bcd), 32'h0);
        check("async_rst_ft", 32'(frame_tick), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        lz_blank = 1'b0;
        repeat (70) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
